// File: rtl/md_ctrl_pkg.sv
// Shared definitions for the position-read controller.
//   rd_ctrl_state_t : controller FSM states
//   COUNT_WORD_ADDR : cache address holding the home-cell particle count
package md_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_NUM0  = 3'd1,
    RD_NUM1  = 3'd2,
    WAIT_CNT = 3'd3,
    SWEEP    = 3'd4,
    FINISH   = 3'd5
  } rd_ctrl_state_t;

  // The count word lives at address 0; particles are stored 1-based from there.
  localparam int COUNT_WORD_ADDR = 0;

endpackage

// File: rtl/pos_read_controller_if.sv
// Handshake/bus bundle between the position-read controller and its environment.
//   start, back_pressure, ref_particle_count : inputs to the controller
//   phase, reading_particle_num, pause_reading,
//   particle_id, ref_id, rd_addr, busy, done : outputs of the controller
// slave  : controller side
// master : environment side (sequencer driver / preprocessor)
interface pos_read_controller_if #(
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int ADDR_WIDTH        = 7
);

  logic                         start;
  logic                         back_pressure;
  logic [PARTICLE_ID_WIDTH-1:0] ref_particle_count;
  logic                         phase;
  logic                         reading_particle_num;
  logic                         pause_reading;
  logic [PARTICLE_ID_WIDTH-1:0] particle_id;
  logic [PARTICLE_ID_WIDTH-1:0] ref_id;
  logic [ADDR_WIDTH-1:0]        rd_addr;
  logic                         busy;
  logic                         done;

  modport slave (
    input  start, back_pressure, ref_particle_count,
    output phase, reading_particle_num, pause_reading,
           particle_id, ref_id, rd_addr, busy, done
  );

  modport master (
    output start, back_pressure, ref_particle_count,
    input  phase, reading_particle_num, pause_reading,
           particle_id, ref_id, rd_addr, busy, done
  );

endinterface

// File: rtl/sweep_counter.sv
// Nested particle_id / ref_id counters with a per-cycle phase toggle.
//   clk, rst     : clock, async active-high reset
//   clr_i        : zero particle_id, ref_id and phase (new evaluation)
//   set_ph1_i    : force phase to 1 (second count-word read)
//   load_i       : begin the sweep at particle_id=1, ref_id=1, phase=0
//   step_i       : advance one sweep cycle; deasserted means hold
//   cnt_i        : home-cell particle count
//   phase_o, particle_id_o, ref_id_o : registered counter values
//   terminal_o   : the next step is the last one of the sweep
// Command priority: clr > set_ph1 > load > step.
module sweep_counter #(
  parameter int PARTICLE_ID_WIDTH = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_i,
  input  logic                         set_ph1_i,
  input  logic                         load_i,
  input  logic                         step_i,
  input  logic [PARTICLE_ID_WIDTH-1:0] cnt_i,
  output logic                         phase_o,
  output logic [PARTICLE_ID_WIDTH-1:0] particle_id_o,
  output logic [PARTICLE_ID_WIDTH-1:0] ref_id_o,
  output logic                         terminal_o
);

  localparam int PW = PARTICLE_ID_WIDTH;

  logic          phase_q, phase_d;
  logic [PW-1:0] pid_q, pid_d;
  logic [PW-1:0] ref_q, ref_d;

  // Terminal index is cnt+1 so the preprocessor sees reading_done; an
  // all-ones count saturates instead of wrapping back to zero.
  function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] v);
    logic [PW-1:0] r;
    if (v == {PW{1'b1}}) begin
      r = v;
    end else begin
      r = v + PW'(1);
    end
    return r;
  endfunction

  // Next-state logic for the nested counters.
  always_comb begin
    phase_d = phase_q;
    pid_d   = pid_q;
    ref_d   = ref_q;
    if (clr_i) begin
      phase_d = 1'b0;
      pid_d   = '0;
      ref_d   = '0;
    end else if (set_ph1_i) begin
      phase_d = 1'b1;
    end else if (load_i) begin
      phase_d = 1'b0;
      pid_d   = PW'(1);
      ref_d   = PW'(1);
    end else if (step_i) begin
      if (!phase_q) begin
        phase_d = 1'b1;
      end else begin
        // Both phases of a particle are done: move to the next particle.
        phase_d = 1'b0;
        if (pid_q == cnt_i) begin
          if (ref_q == cnt_i) begin
            pid_d = sat_inc(cnt_i);
            ref_d = sat_inc(cnt_i);
          end else begin
            pid_d = PW'(1);
            ref_d = ref_q + PW'(1);
          end
        end else begin
          pid_d = pid_q + PW'(1);
        end
      end
    end else begin
      phase_d = phase_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= 1'b0;
      pid_q   <= '0;
      ref_q   <= '0;
    end else begin
      phase_q <= phase_d;
      pid_q   <= pid_d;
      ref_q   <= ref_d;
    end
  end

  assign terminal_o    = phase_q && (pid_q == cnt_i) && (ref_q == cnt_i);
  assign phase_o       = phase_q;
  assign particle_id_o = pid_q;
  assign ref_id_o      = ref_q;

endmodule

// File: rtl/pos_read_controller.sv
// Upstream sequencer for the position-data preprocessor. Reads the count
// word in both phases, waits for the count to return, then sweeps every
// reference particle against every broadcast particle of the home cell in
// both phases, holding while the filters signal back-pressure.
//   clk, rst : clock, async active-high reset
//   bus      : pos_read_controller_if.slave (start/back_pressure/count in,
//              phase/reading_particle_num/pause_reading/particle_id/ref_id/
//              rd_addr/busy/done out)
// ADDR_WIDTH must be >= PARTICLE_ID_WIDTH; COUNT_LATENCY must be >= 1.
module pos_read_controller
  import md_ctrl_pkg::*;
#(
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int ADDR_WIDTH        = 7,
  parameter int COUNT_LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  pos_read_controller_if.slave bus
);

  localparam int PW = PARTICLE_ID_WIDTH;

  rd_ctrl_state_t state_q;
  logic           reading_q;
  logic           pause_q;
  logic           busy_q;
  logic           done_q;
  logic [PW-1:0]  cnt_q;
  logic [7:0]     wait_q;

  logic           last_wait_s;
  logic           clr_s, set_ph1_s, load_s, step_s;
  logic           phase_s, terminal_s;
  logic [PW-1:0]  pid_s, ref_s;

  assign last_wait_s = (wait_q == 8'(COUNT_LATENCY - 1));

  // Counter commands are decoded from the current state so the counter
  // updates on the same edge as the FSM transition.
  always_comb begin
    clr_s     = 1'b0;
    set_ph1_s = 1'b0;
    load_s    = 1'b0;
    step_s    = 1'b0;
    case (state_q)
      IDLE: begin
        clr_s = bus.start;
      end
      RD_NUM0: begin
        set_ph1_s = 1'b1;
      end
      WAIT_CNT: begin
        if (last_wait_s && (bus.ref_particle_count != '0)) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      SWEEP: begin
        step_s = !bus.back_pressure;
      end
      default: begin
        clr_s = 1'b0;
      end
    endcase
  end

  sweep_counter #(
    .PARTICLE_ID_WIDTH(PW)
  ) u_sweep (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (clr_s),
    .set_ph1_i    (set_ph1_s),
    .load_i       (load_s),
    .step_i       (step_s),
    .cnt_i        (cnt_q),
    .phase_o      (phase_s),
    .particle_id_o(pid_s),
    .ref_id_o     (ref_s),
    .terminal_o   (terminal_s)
  );

  // Controller FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      reading_q <= 1'b0;
      pause_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      wait_q    <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q  <= 1'b0;
          pause_q <= 1'b0;
          if (bus.start) begin
            state_q   <= RD_NUM0;
            busy_q    <= 1'b1;
            reading_q <= 1'b1;
          end else begin
            busy_q    <= 1'b0;
            reading_q <= 1'b0;
          end
        end
        RD_NUM0: begin
          state_q   <= RD_NUM1;
          reading_q <= 1'b1;
        end
        RD_NUM1: begin
          state_q   <= WAIT_CNT;
          reading_q <= 1'b0;
          wait_q    <= 8'd0;
        end
        WAIT_CNT: begin
          if (last_wait_s) begin
            cnt_q <= bus.ref_particle_count;
            if (bus.ref_particle_count == '0) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q <= SWEEP;
            end
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        SWEEP: begin
          // pause_reading is back_pressure delayed by one cycle; the counter
          // holds on the same edge, so the frozen values stay on the bus.
          pause_q <= bus.back_pressure;
          if (!bus.back_pressure && terminal_s) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end else begin
            state_q <= SWEEP;
          end
        end
        FINISH: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          pause_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          reading_q <= 1'b0;
          pause_q   <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  // particle_id is cleared on start, so during the count-word reads the
  // address below is COUNT_WORD_ADDR without a separate mux.
  assign bus.rd_addr              = ADDR_WIDTH'(pid_s);
  assign bus.particle_id          = pid_s;
  assign bus.ref_id               = ref_s;
  assign bus.phase                = phase_s;
  assign bus.reading_particle_num = reading_q;
  assign bus.pause_reading        = pause_q;
  assign bus.busy                 = busy_q;
  assign bus.done                 = done_q;

endmodule
